// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: MSB-first bits framed by din_valid become WIDTH-bit words, 1 clock after the last bit; no backpressure.
// Defining PARITY_CHECK_EN appends an even-parity bit to each frame and adds the parity_err strobe.
module serial_to_parallel #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_serial,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout_parallel,
  output logic             dout_valid,
  output logic             frame_err,
`ifdef PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic             busy
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shift;

  logic [WIDTH-1:0]   w_shift_nxt;
  logic               w_last_bit;

  // Top bit of the concatenation falls off: only the newest WIDTH bits matter.
  assign w_shift_nxt = WIDTH'({r_shift, din_serial});
  assign w_last_bit  = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      dout_parallel <= '0;
      dout_valid    <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err    <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (din_valid) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= CNT_W'(1);
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!din_valid) begin
            frame_err <= 1'b1;
            r_cnt     <= '0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_last_bit) begin
`ifdef PARITY_CHECK_EN
            // Data already sits in r_shift; the incoming bit is the parity bit.
            if (^{r_shift, din_serial} == 1'b0) begin
              dout_parallel <= r_shift;
              dout_valid    <= 1'b1;
            end else begin
              parity_err    <= 1'b1;
            end
`else
            dout_parallel <= w_shift_nxt;
            dout_valid    <= 1'b1;
`endif
            r_cnt   <= '0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomised and directed bench for serial_to_parallel with a queue-based scoreboard.
module tb_serial_to_parallel;
  localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FLEN = PAR ? WIDTH + 1 : WIDTH;

  logic             clk;
  logic             rstn;
  logic             din_serial;
  logic             din_valid;
  logic [WIDTH-1:0] dout_parallel;
  logic             dout_valid;
  logic             frame_err;
  logic             busy;
  logic             perr;

  serial_to_parallel #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .din_serial    (din_serial),
    .din_valid     (din_valid),
    .dout_parallel (dout_parallel),
    .dout_valid    (dout_valid),
    .frame_err     (frame_err),
`ifdef PARITY_CHECK_EN
    .parity_err    (perr),
`endif
    .busy          (busy)
  );
`ifndef PARITY_CHECK_EN
  assign perr = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             vld;
    logic             err;
    logic             perr;
    logic             busy;
    logic [WIDTH-1:0] hold;
  } cyc_t;

  typedef struct {
    int               kind;  // 0 word, 1 frame error, 2 parity error
    logic [WIDTH-1:0] data;
  } evt_t;

  cyc_t cq[$];
  evt_t eq[$];
  bit   frame[$];
  logic [WIDTH-1:0] last_word;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: collect frame bits in a list; words are formed arithmetically once complete.
  task automatic cyc(input bit rst, input bit v, input bit b);
    cyc_t r;
    evt_t e;
    logic [WIDTH-1:0] word;
    int ones;
    @(negedge clk);
    rstn = !rst;
    din_valid = v;
    din_serial = b;
    @(posedge clk);
    r.vld = 0; r.err = 0; r.perr = 0;
    word = '0;
    if (rst) begin
      frame.delete();
      last_word = '0;
    end else if (v) begin
      frame.push_back(b);
      if (frame.size() == FLEN) begin
        ones = 0;
        for (int i = 0; i < FLEN; i++) ones += int'(frame[i]);
        for (int i = 0; i < WIDTH; i++) word = WIDTH'(word * 2 + WIDTH'(frame[i]));
        if (PAR && (ones % 2 == 1)) r.perr = 1;
        else begin
          r.vld = 1;
          last_word = word;
        end
        frame.delete();
      end
    end else if (frame.size() != 0) begin
      r.err = 1;
      frame.delete();
    end
    r.busy = (frame.size() != 0);
    r.hold = last_word;
    cq.push_back(r);
    if (r.vld)  begin e.kind = 0; e.data = word; eq.push_back(e); end
    if (r.err)  begin e.kind = 1; e.data = '0;   eq.push_back(e); end
    if (r.perr) begin e.kind = 2; e.data = '0;   eq.push_back(e); end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit bad_par);
    for (int i = WIDTH - 1; i >= 0; i--) cyc(0, 1, w[i]);
    if (PAR) cyc(0, 1, (^w) ^ bad_par);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  // Monitor: per-cycle timing/state check plus event pop whenever a strobe appears.
  initial begin
    cyc_t r;
    evt_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        r = cq.pop_front();
        chk("dout_valid", 32'(dout_valid), 32'(r.vld));
        chk("frame_err", 32'(frame_err), 32'(r.err));
        chk("parity_err", 32'(perr), 32'(r.perr));
        chk("busy", 32'(busy), 32'(r.busy));
        chk("dout_hold", 32'(dout_parallel), 32'(r.hold));
        if (dout_valid && frame_err) chk("strobe_excl", 32'd1, 32'd0);
        if (dout_valid || frame_err || perr) begin
          kind = dout_valid ? 0 : (frame_err ? 1 : 2);
          if (eq.size() == 0) chk("unexpected_strobe", 32'(kind), 32'hFFFF_FFFF);
          else begin
            e = eq.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == 0) chk("word", 32'(dout_parallel), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    last_word = '0;
    rstn = 1'b0;
    din_valid = 1'b0;
    din_serial = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    idle(2);
    send_word(8'hA5, 0);
    idle(2);
    send_word(8'h3C, 0);
    send_word(8'hC3, 0);
    idle(2);
    send_word(8'hA5, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1);
    idle(2);
    send_word(8'h0F, 0);
    cyc(0, 1, 1); cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 1);
    cyc(1, 0, 0);
    send_word(8'h81, 0);
    idle(3);
    send_word(8'h5A, 0);
    idle(3);
    send_word(8'hE7, 0);
    idle(1);
    if (PAR) begin
      send_word(8'hA5, 0);
      send_word(8'hA5, 1);
      idle(2);
    end
    send_word(8'hFF, 0);
    send_word(8'h00, 0);
    idle(1);

    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)));
    idle(4);

    @(negedge clk);
    @(negedge clk);
    chk("pending_cycles", 32'(cq.size()), 32'd0);
    chk("pending_events", 32'(eq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
